// File: rtl/exe_arb_pkg.sv
// Shared definitions for the two-requester execution-unit arbiter.
// Holds the controller state encoding, status/counter widths, the default
// operand/opcode widths and a saturating increment helper.
package exe_arb_pkg;

  localparam int STATUS_W  = 4;
  localparam int ERR_CNT_W = 8;
  localparam int DEF_BITS  = 4;
  localparam int DEF_N     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/exe_unit_w22.sv
// Shared execution unit: combinational ALU followed by a result/status
// register, so results appear one clock after the operands are presented.
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_argA, i_argB       operands (BITS)
//   i_oper               opcode (N): 0 add, 1 sub, 2 xor, 3 divide
//   o_result             registered result (BITS)
//   o_status             registered {error, overflow, odd, zero}
// Add flags carry-out as overflow, sub flags borrow; divide by zero and any
// opcode beyond 3 report error with a zero result.
module exe_unit_w22
  import exe_arb_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int N    = DEF_N
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [BITS-1:0]     i_argA,
  input  logic [BITS-1:0]     i_argB,
  input  logic [N-1:0]        i_oper,
  output logic [BITS-1:0]     o_result,
  output logic [STATUS_W-1:0] o_status
);

  logic [BITS:0]         add_full;
  logic [BITS:0]         sub_full;
  logic [BITS-1:0]       result_d, result_q;
  logic [STATUS_W-1:0]   status_d, status_q;
  logic                  err_w, ovf_w;

  assign add_full = {1'b0, i_argA} + {1'b0, i_argB};
  assign sub_full = {1'b0, i_argA} - {1'b0, i_argB};

  always_comb begin
    result_d = '0;
    err_w    = 1'b0;
    ovf_w    = 1'b0;
    case (i_oper)
      N'(0): begin
        result_d = add_full[BITS-1:0];
        ovf_w    = add_full[BITS];
      end
      N'(1): begin
        result_d = sub_full[BITS-1:0];
        ovf_w    = sub_full[BITS];
      end
      N'(2): result_d = i_argA ^ i_argB;
      N'(3): begin
        if (i_argB == '0) begin
          err_w = 1'b1;
        end else begin
          result_d = i_argA / i_argB;
        end
      end
      default: err_w = 1'b1;
    endcase
    status_d = {err_w, ovf_w, result_d[0], (result_d == '0)};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      result_q <= '0;
      status_q <= '0;
    end else begin
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign o_result = result_q;
  assign o_status = status_q;

endmodule

// File: rtl/exe_arbiter.sv
// Round-robin arbiter sharing one exe_unit_w22 between two requesters.
// One transaction at a time: IDLE accepts (ready high for one cycle), EXEC
// lets the unit register its result, RESP presents it to the owner until
// consumed. Response valid therefore follows acceptance by two cycles.
//   i_clk, i_rst                       clock, asynchronous active-high reset
//   i_reqK_valid / o_reqK_ready        request handshake, K in {0,1}
//   i_reqK_argA/argB/oper              request operands and opcode
//   o_rspK_valid / i_rspK_ready        response handshake
//   o_rspK_result / o_rspK_status      response payload
//   o_busy                             controller not in IDLE
//   o_err_cnt                          delivered error responses, saturating
module exe_arbiter
  import exe_arb_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int N    = DEF_N
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req0_valid,
  output logic                 o_req0_ready,
  input  logic [BITS-1:0]      i_req0_argA,
  input  logic [BITS-1:0]      i_req0_argB,
  input  logic [N-1:0]         i_req0_oper,
  input  logic                 i_req1_valid,
  output logic                 o_req1_ready,
  input  logic [BITS-1:0]      i_req1_argA,
  input  logic [BITS-1:0]      i_req1_argB,
  input  logic [N-1:0]         i_req1_oper,
  output logic                 o_rsp0_valid,
  input  logic                 i_rsp0_ready,
  output logic [BITS-1:0]      o_rsp0_result,
  output logic [STATUS_W-1:0]  o_rsp0_status,
  output logic                 o_rsp1_valid,
  input  logic                 i_rsp1_ready,
  output logic [BITS-1:0]      o_rsp1_result,
  output logic [STATUS_W-1:0]  o_rsp1_status,
  output logic                 o_busy,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  state_e                 state_d, state_q;
  logic                   owner_d, owner_q;
  logic                   last_owner_d, last_owner_q;
  logic [BITS-1:0]        arg_a_d, arg_a_q;
  logic [BITS-1:0]        arg_b_d, arg_b_q;
  logic [N-1:0]           oper_d, oper_q;
  logic [ERR_CNT_W-1:0]   err_cnt_d, err_cnt_q;

  logic                   grant_any;
  logic                   grant_idx;
  logic                   accept;
  logic                   rsp_ready_own;
  logic                   in_resp;
  logic                   unit_rst_n;
  logic [BITS-1:0]        unit_result;
  logic [STATUS_W-1:0]    unit_status;

  // On a tie the requester that did not win last time goes first; a lone
  // requester wins regardless of history.
  assign grant_any = i_req0_valid | i_req1_valid;
  assign grant_idx = (i_req0_valid && i_req1_valid) ? ~last_owner_q : i_req1_valid;

  // Readies are combinational so acceptance happens in the valid cycle;
  // they are also held low while reset is asserted.
  assign accept       = (state_q == ST_IDLE) && grant_any && !i_rst;
  assign o_req0_ready = accept && !grant_idx;
  assign o_req1_ready = accept &&  grant_idx;

  // Only the owner's response ready can close a transaction.
  assign rsp_ready_own = owner_q ? i_rsp1_ready : i_rsp0_ready;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    arg_a_d      = arg_a_q;
    arg_b_d      = arg_b_q;
    oper_d       = oper_q;
    err_cnt_d    = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EXEC;
          owner_d = grant_idx;
          arg_a_d = grant_idx ? i_req1_argA : i_req0_argA;
          arg_b_d = grant_idx ? i_req1_argB : i_req0_argB;
          oper_d  = grant_idx ? i_req1_oper : i_req0_oper;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready_own) begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
          if (unit_status[STATUS_W-1]) begin
            err_cnt_d = sat_inc(err_cnt_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      arg_a_q      <= '0;
      arg_b_q      <= '0;
      oper_q       <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      arg_a_q      <= arg_a_d;
      arg_b_q      <= arg_b_d;
      oper_q       <= oper_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign unit_rst_n = ~i_rst;

  // The operand registers stay constant until the next acceptance, so the
  // unit's registered outputs remain stable throughout RESP backpressure.
  exe_unit_w22 #(
    .BITS (BITS),
    .N    (N)
  ) u_exe (
    .i_clk    (i_clk),
    .i_rst_n  (unit_rst_n),
    .i_argA   (arg_a_q),
    .i_argB   (arg_b_q),
    .i_oper   (oper_q),
    .o_result (unit_result),
    .o_status (unit_status)
  );

  assign in_resp       = (state_q == ST_RESP);
  assign o_rsp0_valid  = in_resp && !owner_q;
  assign o_rsp1_valid  = in_resp &&  owner_q;
  assign o_rsp0_result = o_rsp0_valid ? unit_result : '0;
  assign o_rsp0_status = o_rsp0_valid ? unit_status : '0;
  assign o_rsp1_result = o_rsp1_valid ? unit_result : '0;
  assign o_rsp1_status = o_rsp1_valid ? unit_status : '0;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_exe_arbiter.sv
// Bench for exe_arbiter: randomized and directed traffic checked each cycle
// against a transaction-level reference (age since acceptance, owner,
// expected payload computed arithmetically from the operands).
module tb_exe_arbiter;

  localparam int BITS = 4;
  localparam int N    = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            v0 = 1'b0, v1 = 1'b0;
  logic            r0_o, r1_o;
  logic [BITS-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [N-1:0]    op0 = '0, op1 = '0;
  logic            rv0_o, rv1_o;
  logic            rr0 = 1'b0, rr1 = 1'b0;
  logic [BITS-1:0] res0_o, res1_o;
  logic [3:0]      st0_o, st1_o;
  logic            busy_o;
  logic [7:0]      err_o;

  int total = 0;
  int bad   = 0;

  // Reference state.
  int m_age   = -1;
  bit m_owner = 1'b0;
  bit m_last  = 1'b1;
  int m_err   = 0;
  int m_res   = 0;
  int m_st    = 0;
  bit obs_r0, obs_r1;

  always #5 clk = ~clk;

  exe_arbiter #(.BITS(BITS), .N(N)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req0_valid  (v0),
    .o_req0_ready  (r0_o),
    .i_req0_argA   (a0),
    .i_req0_argB   (b0),
    .i_req0_oper   (op0),
    .i_req1_valid  (v1),
    .o_req1_ready  (r1_o),
    .i_req1_argA   (a1),
    .i_req1_argB   (b1),
    .i_req1_oper   (op1),
    .o_rsp0_valid  (rv0_o),
    .i_rsp0_ready  (rr0),
    .o_rsp0_result (res0_o),
    .o_rsp0_status (st0_o),
    .o_rsp1_valid  (rv1_o),
    .i_rsp1_ready  (rr1),
    .o_rsp1_result (res1_o),
    .o_rsp1_status (st1_o),
    .o_busy        (busy_o),
    .o_err_cnt     (err_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Arithmetic reference of the execution unit for 4-bit operands.
  function automatic void ref_exe(input int a, input int b, input int op,
                                  output int res, output int st);
    int e, o, r;
    e = 0; o = 0; r = 0;
    case (op)
      0: begin r = a + b; o = (r > 15) ? 1 : 0; r = r % 16; end
      1: begin r = a - b; o = (r < 0) ? 1 : 0; if (r < 0) r += 16; end
      2: r = a ^ b;
      default: begin
        if (b == 0) e = 1;
        else r = a / b;
      end
    endcase
    res = r;
    st  = 8 * e + 4 * o + 2 * (r % 2) + ((r == 0) ? 1 : 0);
  endfunction

  // One clock cycle: drive at the falling edge, check 1 time unit later,
  // then advance the reference across the following rising edge.
  task automatic step(input logic iv0, input logic iv1,
                      input logic [3:0] ia0, input logic [3:0] ib0, input logic [1:0] io0,
                      input logic [3:0] ia1, input logic [3:0] ib1, input logic [1:0] io1,
                      input logic ir0, input logic ir1);
    bit idle, any, g, e_r0, e_r1, e_v0, e_v1;
    @(negedge clk);
    v0 = iv0; v1 = iv1; a0 = ia0; b0 = ib0; op0 = io0;
    a1 = ia1; b1 = ib1; op1 = io1; rr0 = ir0; rr1 = ir1;
    #1;
    idle = (m_age < 0);
    any  = iv0 | iv1;
    g    = (iv0 && iv1) ? !m_last : iv1;
    e_r0 = idle && any && !g;
    e_r1 = idle && any && g;
    e_v0 = (m_age >= 2) && !m_owner;
    e_v1 = (m_age >= 2) && m_owner;
    obs_r0 = r0_o;
    obs_r1 = r1_o;
    check_eq("ready0", 32'(r0_o), 32'(e_r0));
    check_eq("ready1", 32'(r1_o), 32'(e_r1));
    check_eq("rsp0_valid", 32'(rv0_o), 32'(e_v0));
    check_eq("rsp1_valid", 32'(rv1_o), 32'(e_v1));
    check_eq("busy", 32'(busy_o), 32'(!idle));
    check_eq("err_cnt", 32'(err_o), m_err);
    if (e_v0) begin
      check_eq("rsp0_result", 32'(res0_o), m_res);
      check_eq("rsp0_status", 32'(st0_o), m_st);
    end
    if (e_v1) begin
      check_eq("rsp1_result", 32'(res1_o), m_res);
      check_eq("rsp1_status", 32'(st1_o), m_st);
    end
    if (idle) begin
      if (any) begin
        m_age   = 1;
        m_owner = g;
        if (g) ref_exe(int'(ia1), int'(ib1), int'(io1), m_res, m_st);
        else   ref_exe(int'(ia0), int'(ib0), int'(io0), m_res, m_st);
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (m_owner ? ir1 : ir0) begin
      m_age  = -1;
      m_last = m_owner;
      if ((m_st & 8) != 0) m_err = (m_err < 255) ? m_err + 1 : 255;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready0"}, 32'(r0_o), 0);
    check_eq({tag, "_ready1"}, 32'(r1_o), 0);
    check_eq({tag, "_rsp0_valid"}, 32'(rv0_o), 0);
    check_eq({tag, "_rsp1_valid"}, 32'(rv1_o), 0);
    check_eq({tag, "_rsp0_res"}, 32'({res0_o, st0_o}), 0);
    check_eq({tag, "_rsp1_res"}, 32'({res1_o, st1_o}), 0);
    check_eq({tag, "_busy"}, 32'(busy_o), 0);
    check_eq({tag, "_err_cnt"}, 32'(err_o), 0);
  endtask

  // Raise reset between clock edges with both requesters asserting valid,
  // hold it across a rising edge, then release with valids low.
  task automatic do_reset();
    @(negedge clk);
    v0 = 1'b1; v1 = 1'b1; rr0 = 1'b1; rr1 = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    @(negedge clk);
    rst = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    m_age = -1; m_last = 1'b1; m_err = 0;
  endtask

  task automatic rand_step(input int pv, input int pr);
    step($urandom_range(99) < pv, $urandom_range(99) < pv,
         4'($urandom), 4'($urandom), 2'($urandom),
         4'($urandom), 4'($urandom), 2'($urandom),
         $urandom_range(99) < pr, $urandom_range(99) < pr);
  endtask

  logic [3:0] bp_res, bp_st;

  initial begin
    do_reset();

    // Single request from requester 0: 3 - 1.
    step(1, 0, 4'h3, 4'h1, 2'd1, 4'h0, 4'h0, 2'd0, 1, 1);
    check_eq("single_ready0", 32'(obs_r0), 1);
    step(0, 0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 2'd0, 1, 1);
    step(0, 0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 2'd0, 1, 1);
    check_eq("single_result", 32'(res0_o), 2);
    check_eq("single_status", 32'(st0_o), 0);
    step(0, 0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 2'd0, 1, 1);

    // Tie and fairness: grants expected at cycles 1,4,7,10 alternating 0,1.
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      step(1, 1, 4'($urandom), 4'($urandom), 2'($urandom),
           4'($urandom), 4'($urandom), 2'($urandom), 1, 1);
      check_eq("fair_r0", 32'(obs_r0), 32'((i == 1) || (i == 7)));
      check_eq("fair_r1", 32'(obs_r1), 32'((i == 4) || (i == 10)));
    end

    // Backpressure on requester 0 while requester 1 waits.
    step(1, 0, 4'h9, 4'h4, 2'd0, 4'h0, 4'h0, 2'd0, 0, 0);
    step(0, 1, 4'h0, 4'h0, 2'd0, 4'h2, 4'h7, 2'd2, 0, 0);
    step(1, 1, 4'h1, 4'h1, 2'd3, 4'h2, 4'h7, 2'd2, 0, 1);
    bp_res = res0_o;
    bp_st  = st0_o;
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 4'($urandom), 4'($urandom), 2'($urandom), 4'h2, 4'h7, 2'd2, 0, 1);
      check_eq("bp_res_stable", 32'(res0_o), 32'(bp_res));
      check_eq("bp_st_stable", 32'(st0_o), 32'(bp_st));
    end
    check_eq("bp_result", 32'(bp_res), 13);
    step(0, 1, 4'h0, 4'h0, 2'd0, 4'h2, 4'h7, 2'd2, 1, 0);
    step(0, 1, 4'h0, 4'h0, 2'd0, 4'h2, 4'h7, 2'd2, 1, 1);
    check_eq("bp_held_grant1", 32'(obs_r1), 1);
    step(0, 0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 2'd0, 1, 1);
    step(0, 0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 2'd0, 1, 1);

    // Reset while in EXEC: transaction discarded, next tie goes to 0.
    step(0, 1, 4'h5, 4'h5, 2'd0, 4'h5, 4'h5, 2'd0, 1, 1);
    do_reset();
    for (int i = 0; i < 4; i++)
      step(0, 0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 2'd0, 1, 1);
    step(1, 1, 4'h6, 4'h2, 2'd3, 4'h1, 4'h1, 2'd0, 1, 1);
    check_eq("post_rst_tie0", 32'(obs_r0), 1);
    step(0, 0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 2'd0, 1, 1);
    step(0, 0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 2'd0, 1, 1);

    // Error counter saturation: 260 divide-by-zero responses.
    do_reset();
    for (int i = 0; i < 780; i++)
      step(1, 0, 4'($urandom), 4'h0, 2'd3, 4'h0, 4'h0, 2'd0, 1, 1);
    step(0, 0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 2'd0, 1, 1);
    check_eq("err_sat", 32'(err_o), 255);
    for (int i = 0; i < 30; i++)
      step(0, 1, 4'h0, 4'h0, 2'd0, 4'h1, 4'h1, 2'd0, 1, 1);
    check_eq("err_hold", 32'(err_o), 255);

    // Randomized traffic with random backpressure and occasional resets.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rand_step(60, 60);
      if (i % 500 == 250) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exe_arbiter.md
EXE_ARBITER -- requirements
Module: exe_arbiter

Interface
REQ-001 Parameter BITS, default 4, operand/result width; SHALL match the shared execution unit.
REQ-002 Parameter N, default 2, opcode width; SHALL match the shared execution unit.
REQ-003 i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_req0_valid / i_req1_valid  in  1  requester k has an operation pending.
REQ-006 o_req0_ready / o_req1_ready  out  1  requester k's operation is accepted this cycle.
REQ-007 i_reqk_argA, i_reqk_argB  in  BITS  operands of requester k.
REQ-008 i_reqk_oper  in  N  opcode of requester k.
REQ-009 o_rspk_valid  out  1  response for requester k is present.
REQ-010 i_rspk_ready  in  1  requester k consumes the response.
REQ-011 o_rspk_result  out  BITS  result for requester k.
REQ-012 o_rspk_status  out  4  status {error, overflow, odd, zero} for requester k.
REQ-013 o_busy  out  1  state is not IDLE.
REQ-014 o_err_cnt  out  8  count of delivered responses with status[3]=1, saturating at 255.

Function
REQ-015 States: IDLE, EXEC, RESP.
- Exactly one transaction is in flight at a time.
REQ-016 IDLE: if any valid, grant one requester and assert only its ready.
- Capture its argA/argB/oper into operand registers and its index into owner.
- Go to EXEC.
- With no valid, stay in IDLE with both readies low.
REQ-017 Arbitration is round-robin.
- With both valid, grant the requester other than last_owner.
- With one valid, grant it regardless of last_owner.
REQ-018 EXEC: operand registers drive the execution unit for exactly one cycle.
- Go to RESP unconditionally.
REQ-019 RESP: assert o_rsp<owner>_valid with result/status taken from the unit's registered outputs.
- The other requester's rsp_valid stays 0.
- Payload holds stable while valid && !ready.
REQ-020 In RESP with i_rsp<owner>_ready=1:
- Go to IDLE.
- Set last_owner=owner.
- Increment o_err_cnt if status[3]=1 and the count is below 255.
REQ-021 Latency: acceptance in cycle k gives rsp_valid in cycle k+2.
- Minimum initiation interval is 3 cycles; ready is never asserted outside IDLE.
REQ-022 i_rsp ready of the non-owner is ignored.
- Valid on a requester in EXEC or RESP is held off, not lost.
REQ-023 Non-granted ready SHALL be 0 in every state.
- Inputs are sampled only on the ready cycle; later input changes do not affect the transaction.

Reset
REQ-024 i_rst=1 asynchronously forces:
- State to IDLE.
- All readies, rsp_valids, results and statuses, o_busy and o_err_cnt to 0.
- Operand registers to 0.
- last_owner=1, so requester 0 wins the first tie.
REQ-025 Reset in EXEC or RESP discards the in-flight transaction; no response is ever delivered for it.
REQ-026 The execution unit's active-low reset SHALL be driven by the inverse of i_rst.

Structure
REQ-027 Shared package exe_arb_pkg SHALL hold:
- The state enum (IDLE, EXEC, RESP).
- STATUS_W=4, ERR_CNT_W=8.
- Default BITS/N constants.
REQ-028 Exactly one sub-module instance: exe_unit_w22 #(BITS), fed from the operand registers.
REQ-029 Response outputs SHALL be combinational from state, owner and unit outputs; no extra pipeline register.

Verification
REQ-030 Single request: req0 valid in cycle 1 (argA=4'h3, argB=4'h1, oper=1).
- Response: ready0=1 in cycle 1, rsp0_valid=1 in cycle 3.
- Result/status equal a standalone exe_unit_w22 model for those operands.
- rsp1_valid stays 0.
REQ-031 Tie then fairness: both valid continuously from cycle 1, rsp ready always 1.
- Response: grants alternate 0,1,0,1 at cycles 1,4,7,10.
REQ-032 Backpressure: rsp0_ready held 0 for 5 cycles after rsp0_valid.
- Response: payload stable all 5 cycles; no ready asserted; IDLE re-entered the cycle after ready=1.
REQ-033 Reset mid-op: i_rst pulsed while in EXEC.
- Response: all outputs 0 immediately; no rsp_valid afterward.
- The next tie grants requester 0.
REQ-034 Error counter: 260 responses with status[3]=1.
- Response: o_err_cnt reads 255 and holds.
- Responses with status[3]=0 do not change it.
